// File: rtl/cdc_2phase_rx_pkg.sv
// Shared constants and helpers for the two-phase CDC receiver.
package cdc_2phase_rx_pkg;

  localparam int unsigned DropCntWidth = 16;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/cdc_2phase_rx_fifo.sv
// Register-based FIFO behind the CDC receiver.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : drop all contents (pointers back to 0)
//   push_i/data_i : write one item (caller guarantees !full_o)
//   pop_i         : advance the read pointer (caller guarantees !empty_o)
//   data_o        : storage at the read pointer (no fall-through)
//   full_o/empty_o/fill_o : status derived from the wrap-bit pointers
module cdc_2phase_rx_fifo
  import cdc_2phase_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic                           pop_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [fill_width(DEPTH)-1:0]   fill_o
);

  localparam int unsigned AddrWidth = $clog2(DEPTH);
  localparam int unsigned PtrWidth  = AddrWidth + 1;
  localparam int unsigned FillWidth = fill_width(DEPTH);

  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Next-state for storage and pointers; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q[AddrWidth-1:0]] = data_i;
        wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Same address with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]) &&
                   (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign fill_o  = FillWidth'(wr_ptr_q - rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[AddrWidth-1:0]];

endmodule

// File: rtl/cdc_2phase_rx_buffered.sv
// Destination half of a two-phase req/ack/data CDC link with a local FIFO.
// Each request edge is synchronized, its data captured into the FIFO, and the
// acknowledge toggled on capture, so downstream backpressure only stalls the
// source once the FIFO is full.
//   clk_i, rst_ni   : receiver clock, synchronous active-low reset
//   clear_i         : one-cycle flush; drops FIFO contents and any pending item
//   async_req_i     : two-phase request from the source domain
//   async_ack_o     : two-phase acknowledge back to the source (registered)
//   async_data_i    : source data, stable while a request is outstanding
//   data_o/valid_o/ready_i : FIFO head with valid/ready handshake
//   fill_o          : FIFO occupancy
//   drop_cnt_o      : saturating count of items discarded by clear
// Build option: define CDC_2PHASE_RX_DROP_CNT_EN to implement the drop counter;
// otherwise drop_cnt_o is tied to zero.
module cdc_2phase_rx_buffered
  import cdc_2phase_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          async_req_i,
  output logic                          async_ack_o,
  input  logic [DATA_WIDTH-1:0]         async_data_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [fill_width(DEPTH)-1:0]  fill_o,
  output logic [DropCntWidth-1:0]       drop_cnt_o
);

  (* async_reg = "true", dont_touch = "true" *)
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic req_q, req_d;
  logic ack_q, ack_d;
  logic pending;
  logic push;
  logic pop;
  logic full;
  logic empty;

  // Request synchronizer, capture/ack control and pop qualification.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_req_i};
    req_d   = sync_q[SYNC_STAGES-1];
    pending = (req_q != ack_q);
    push    = pending && !full && !clear_i;
    valid_o = !empty && !clear_i;
    pop     = valid_o && ready_i;
    ack_d   = ack_q;
    if (clear_i) begin
      // Absorb (and thereby drop) whatever request has reached req_q.
      ack_d = req_q;
    end else if (push) begin
      ack_d = ~ack_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      req_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      req_q  <= req_d;
      ack_q  <= ack_d;
    end
  end

  assign async_ack_o = ack_q;

  cdc_2phase_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (push),
    .data_i  (async_data_i),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill_o)
  );

`ifdef CDC_2PHASE_RX_DROP_CNT_EN
  localparam int unsigned SumWidth = DropCntWidth + 1;

  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic [SumWidth-1:0]     drop_sum;

  // Items lost on clear: everything stored plus the one pending request.
  always_comb begin
    drop_sum   = SumWidth'(drop_cnt_q) + SumWidth'(fill_o) + SumWidth'(pending);
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      drop_cnt_d = drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cdc_2phase_rx_buffered.sv
// Bench for cdc_2phase_rx_buffered: an emulated two-phase source feeds queued
// items, a scoreboard queue holds every item handed to the link in order, and
// each consumer handshake is compared against the queue head.
module tb_cdc_2phase_rx_buffered;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 3;

`ifdef CDC_2PHASE_RX_DROP_CNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          async_req_i;
  logic          async_ack_o;
  logic [DW-1:0] async_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [2:0]    fill_o;
  logic [15:0]   drop_cnt_o;

  int checks     = 0;
  int errors     = 0;
  int drop_model = 0;
  int dropped;

  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  cdc_2phase_rx_buffered #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .async_req_i  (async_req_i),
    .async_ack_o  (async_ack_o),
    .async_data_i (async_data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .fill_o       (fill_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One receiver cycle: source launches next item when idle, consumer
  // handshake is scored, then advance to the next falling edge.
  task automatic step();
    if (async_req_i == async_ack_o && tx_q.size() != 0) begin
      async_data_i = tx_q.pop_front();
      exp_q.push_back(async_data_i);
      async_req_i = ~async_req_i;
    end
    if (valid_o && ready_i) begin
      if (exp_q.size() != 0) chk("data_order", 64'(data_o), 64'(exp_q.pop_front()));
      else                   chk("unexpected_pop", 64'(valid_o), 64'(0));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max_steps, input bit rnd);
    for (int i = 0; i < max_steps && (tx_q.size() != 0 || exp_q.size() != 0); i++) begin
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    ready_i = 1'b0;
    chk("drain_done", 64'(tx_q.size() + exp_q.size()), 64'(0));
  endtask

  task automatic chk_drop(input string tag);
    chk(tag, 64'(drop_cnt_o), DropEn ? 64'(drop_model) : 64'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; async_req_i = 1'b0;
    async_data_i = '0; ready_i = 1'b0;
    @(negedge clk);
    step(); step();
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_ack",   64'(async_ack_o), 64'(0));
    chk("rst_fill",  64'(fill_o), 64'(0));
    chk("rst_data",  64'(data_o), 64'(0));
    chk_drop("rst_drop");
    rst_ni = 1'b1;

    // Single item latency: valid SYNC+2 cycles after the request edge.
    ready_i = 1'b1;
    tx_q.push_back(32'hDEADBEEF);
    repeat (SYNC + 1) step();
    chk("lat_valid_early", 64'(valid_o), 64'(0));
    step();
    chk("lat_valid", 64'(valid_o), 64'(1));
    chk("lat_data",  64'(data_o), 64'(32'hDEADBEEF));
    chk("lat_ack",   64'(async_ack_o), 64'(1));
    drain(20, 1'b0);
    chk("single_fill_end", 64'(fill_o), 64'(0));

    // Burst of 6 against a stalled consumer.
    ready_i = 1'b0;
    repeat (6) tx_q.push_back($urandom);
    repeat (40) step();
    chk("burst_fill", 64'(fill_o), 64'(DEPTH));
    chk("burst_ack_withheld", 64'(async_req_i ^ async_ack_o), 64'(1));
    chk("burst_tx_left", 64'(tx_q.size()), 64'(1));
    drain(100, 1'b0);
    chk("burst_fill_end", 64'(fill_o), 64'(0));

    // Full with pending item: pop first, capture on the following cycle.
    repeat (5) tx_q.push_back($urandom);
    repeat (30) step();
    chk("full_fill", 64'(fill_o), 64'(4));
    chk("full_pending", 64'(async_req_i ^ async_ack_o), 64'(1));
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("full_pop_fill", 64'(fill_o), 64'(3));
    step();
    chk("full_recap_fill", 64'(fill_o), 64'(4));
    chk("full_recap_ack", 64'(async_req_i ^ async_ack_o), 64'(0));
    drain(60, 1'b0);
    chk("full_fill_end", 64'(fill_o), 64'(0));

    // Clear with three stored and one pending item.
    repeat (3) tx_q.push_back($urandom);
    repeat (20) step();
    chk("clr_pre_fill", 64'(fill_o), 64'(3));
    tx_q.push_back($urandom);
    repeat (SYNC + 1) step();
    clear_i = 1'b1;
    #1;
    chk("clr_valid_forced", 64'(valid_o), 64'(0));
    dropped = exp_q.size();
    step();
    clear_i = 1'b0;
    exp_q.delete();
    drop_model = (drop_model + dropped > 65535) ? 65535 : drop_model + dropped;
    chk("clr_fill",  64'(fill_o), 64'(0));
    chk("clr_valid", 64'(valid_o), 64'(0));
    chk("clr_ack",   64'(async_req_i ^ async_ack_o), 64'(0));
    chk_drop("clr_drop");
    repeat (6) step();
    chk("clr_no_ghost", 64'(fill_o), 64'(0));

    // Clear while the request edge is still in the synchronizer.
    tx_q.push_back($urandom);
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (6) step();
    chk("clr_sync_fill", 64'(fill_o), 64'(1));
    chk("clr_sync_ack",  64'(async_req_i ^ async_ack_o), 64'(0));
    chk_drop("clr_sync_drop");
    drain(20, 1'b0);

    // Random data with a randomly stalling consumer.
    repeat (24) tx_q.push_back($urandom);
    drain(600, 1'b1);
    chk("rnd_fill_end", 64'(fill_o), 64'(0));
    chk_drop("rnd_drop");

    // Reset both ends mid-burst, with clear also asserted.
    repeat (6) tx_q.push_back($urandom);
    repeat (12) step();
    rst_ni = 1'b0; clear_i = 1'b1; async_req_i = 1'b0;
    tx_q.delete(); exp_q.delete(); drop_model = 0;
    step();
    chk("mid_rst_valid", 64'(valid_o), 64'(0));
    chk("mid_rst_ack",   64'(async_ack_o), 64'(0));
    chk("mid_rst_fill",  64'(fill_o), 64'(0));
    chk("mid_rst_data",  64'(data_o), 64'(0));
    chk_drop("mid_rst_drop");
    rst_ni = 1'b1; clear_i = 1'b0;
    tx_q.push_back(32'h1);
    drain(30, 1'b0);
    chk("post_rst_fill", 64'(fill_o), 64'(0));
    chk_drop("post_rst_drop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
